// File: rtl/sound_scheduler.sv
// ---------------------------------------------------------------------------
// sound_scheduler
//
// Latches single-cycle sound requests from game logic, picks one by fixed
// priority (victory > error > start > drop) and drives the game_sounds
// player. The player has no busy output and samples sound_type on every
// cycle of playback. This block therefore holds snd_type for a computed
// busy time: the playback length, a fixed margin and a silent guard gap.
//
// Parameters:
//   CLK_FREQ      system clock in Hz; long note = CLK_FREQ/10, short = /25
//   GAP_CYCLES    silent guard cycles appended after each sound
//   STROBE_CYCLES length of the low start strobe (>= 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   req_start    in   request pulse, sound type 00
//   req_drop     in   request pulse, sound type 01
//   req_error    in   request pulse, sound type 10
//   req_victory  in   request pulse, sound type 11
//   mute         in   level; while high, requests are discarded and
//                     pending requests are dropped
//   snd_start_n  out  active-low start strobe to the player
//   snd_type     out  sound select to the player, stable while busy
//   busy         out  high whenever a sound is being issued or played
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | nothing in flight; issue the top-priority pending request
//   ST_STROBE | snd_start_n held low for STROBE_CYCLES cycles
//   ST_WAIT   | player running; wait out the rest of the busy time
// ---------------------------------------------------------------------------
module sound_scheduler #(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int GAP_CYCLES    = 250_000,
    parameter int STROBE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_start,
    input  logic       req_drop,
    input  logic       req_error,
    input  logic       req_victory,
    input  logic       mute,
    output logic       snd_start_n,
    output logic [1:0] snd_type,
    output logic       busy
);

    localparam logic [1:0] TYPE_START   = 2'b00;
    localparam logic [1:0] TYPE_DROP    = 2'b01;
    localparam logic [1:0] TYPE_ERROR   = 2'b10;
    localparam logic [1:0] TYPE_VICTORY = 2'b11;

    localparam int LONG_DUR  = CLK_FREQ / 10;
    localparam int SHORT_DUR = CLK_FREQ / 25;
    // Covers the player's input synchroniser and note-register latency.
    localparam int MARGIN    = 8;

    // Busy time from the first low strobe cycle to the first IDLE cycle.
    localparam int TOTAL_START   = 4  * (LONG_DUR  + 1) + MARGIN + GAP_CYCLES;
    localparam int TOTAL_DROP    = 2  * (SHORT_DUR + 1) + MARGIN + GAP_CYCLES;
    localparam int TOTAL_ERROR   = 2  * (LONG_DUR  + 1) + MARGIN + GAP_CYCLES;
    localparam int TOTAL_VICTORY = 13 * (LONG_DUR  + 1) + MARGIN + GAP_CYCLES;

    localparam int BUSY_W = $clog2(TOTAL_VICTORY + 1);
    localparam int STB_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    // The busy counter is loaded in the issue cycle and reaches zero in the
    // last busy cycle, hence the -1.
    localparam logic [BUSY_W-1:0] LOAD_START   = BUSY_W'(TOTAL_START - 1);
    localparam logic [BUSY_W-1:0] LOAD_DROP    = BUSY_W'(TOTAL_DROP - 1);
    localparam logic [BUSY_W-1:0] LOAD_ERROR   = BUSY_W'(TOTAL_ERROR - 1);
    localparam logic [BUSY_W-1:0] LOAD_VICTORY = BUSY_W'(TOTAL_VICTORY - 1);
    localparam logic [STB_W-1:0]  LOAD_STROBE  = STB_W'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STROBE = 2'b01,
        ST_WAIT   = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          pending;
    logic [3:0]          pending_nxt;
    logic [3:0]          req;
    logic [3:0]          clear;
    logic [3:0]          absorb;
    logic                issue;
    logic [1:0]          sel_type;
    logic [BUSY_W-1:0]   busy_load;
    logic [BUSY_W-1:0]   busy_cnt;
    logic [STB_W-1:0]    strobe_cnt;

    // Pending bits are indexed by the sound_type encoding.
    assign req   = {req_victory, req_error, req_drop, req_start};
    assign issue = (state == ST_IDLE) && (pending != 4'b0000) && !mute;

    always_comb begin
        sel_type = TYPE_DROP;
        if (pending[TYPE_VICTORY]) begin
            sel_type = TYPE_VICTORY;
        end else if (pending[TYPE_ERROR]) begin
            sel_type = TYPE_ERROR;
        end else if (pending[TYPE_START]) begin
            sel_type = TYPE_START;
        end
    end

    always_comb begin
        busy_load = LOAD_DROP;
        case (sel_type)
            TYPE_START:   busy_load = LOAD_START;
            TYPE_DROP:    busy_load = LOAD_DROP;
            TYPE_ERROR:   busy_load = LOAD_ERROR;
            TYPE_VICTORY: busy_load = LOAD_VICTORY;
            default:      busy_load = LOAD_DROP;
        endcase
    end

    // Holding mute high clears every cycle, which covers the rising edge and
    // keeps pending empty for as long as requests are being discarded.
    // Start and victory make a queued drop stale, so it is discarded too.
    always_comb begin
        clear  = 4'b0000;
        absorb = 4'b0000;
        if (mute) begin
            clear = 4'b1111;
        end
        if (issue) begin
            clear[sel_type]  = 1'b1;
            absorb[sel_type] = 1'b1;
            if ((sel_type == TYPE_VICTORY) || (sel_type == TYPE_START)) begin
                clear[TYPE_DROP] = 1'b1;
            end
        end
    end

    assign pending_nxt = (pending & ~clear) | (req & ~{4{mute}} & ~absorb);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (strobe_cnt == '0) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (busy_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs. ST_STROBE is the only encoding with bit 0 set, so the
    // strobe decodes from a single flop and cannot glitch.
    always_comb begin
        snd_start_n = (state != ST_STROBE);
        busy        = (state != ST_IDLE);
    end

    // Pending register, counters and the held sound select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 4'b0000;
            strobe_cnt <= '0;
            busy_cnt   <= '0;
            snd_type   <= TYPE_START;
        end else begin
            pending <= pending_nxt;
            if (issue) begin
                snd_type   <= sel_type;
                strobe_cnt <= LOAD_STROBE;
                busy_cnt   <= busy_load;
            end else begin
                if ((state == ST_STROBE) && (strobe_cnt != '0)) begin
                    strobe_cnt <= strobe_cnt - 1'b1;
                end
                if ((state != ST_IDLE) && (busy_cnt != '0)) begin
                    busy_cnt <= busy_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Request scheduler in front of the `game_sounds` player. Game logic raises single-cycle requests for the four sound types. This block latches and prioritises them, and drives the player's active-low start strobe and `sound_type` select. It holds the select stable for the full playback time, because the player has no busy output and samples `sound_type` on every cycle of playback.

## Interface
- `CLK_FREQ`, default 25_000_000: system clock in Hz. Sets note lengths: long = CLK_FREQ/10, short = CLK_FREQ/25.
- `GAP_CYCLES`, default 250_000: silent guard cycles appended after each sound.
- `STROBE_CYCLES`, default 4: length of the low strobe pulse, ≥ 2.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_start`, `req_drop`, `req_error`, `req_victory` in 1 each: single-cycle request pulses.
- `mute` in 1: level. While high, requests are discarded.
- `snd_start_n` out 1: to player `start`. Idle high; low pulse triggers playback.
- `snd_type` out 2: to player `sound_type`. Encoding: 00 start, 01 drop, 10 error, 11 victory.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Pending register: one bit per type.
  - pending_next = (pending & ~clear) | (req & ~mute & ~absorb).
  - Repeated requests while a type is pending merge into the existing bit.
- Selection in IDLE with any pending bit set. Fixed priority: victory > error > start > drop.
- On issue:
  - Load `snd_type` with the selected type.
  - Clear that type's pending bit.
  - Issuing victory or start also clears pending drop (stale).
  - A request for the issued type in the issue cycle is absorbed.
- FSM states: IDLE, STROBE, WAIT.
  - IDLE → STROBE when pending ≠ 0 and mute = 0. Drive `snd_start_n`=0 and load the strobe counter.
  - STROBE: hold `snd_start_n`=0 for STROBE_CYCLES cycles. Then → WAIT with `snd_start_n`=1.
  - WAIT: count down the remainder of the total busy time, then → IDLE.
- Total busy time, counted from the first low strobe cycle to the first IDLE cycle = PLAY(type) + 8 + GAP_CYCLES.
  - The 8 is fixed margin covering player sync and note-register latency.
  - PLAY = n_notes × (dur + 1).
  - Start: 4 × (long + 1).
  - Drop: 2 × (short + 1).
  - Error: 2 × (long + 1).
  - Victory: 13 × (long + 1).
- Arithmetic:
  - Busy counter width = $clog2(13×(CLK_FREQ/10+1) + 8 + GAP_CYCLES + 1).
  - Constants are computed at elaboration. No runtime multiplier.
  - The counter loads once at issue and only decrements.
  - No wrap: the WAIT→IDLE transition occurs at zero.
- `snd_type` changes only at issue. It holds its value through STROBE, WAIT and the following IDLE.
- Mute:
  - Rising `mute` clears all pending bits.
  - An in-flight sound is not aborted, because the player cannot be stopped. Busy timing completes normally.
  - No new issue while `mute`=1.
- No preemption: a victory request during a drop playback waits for IDLE.

## Timing
- Reset values:
  - `snd_start_n`=1, `snd_type`=00, `busy`=0.
  - State IDLE, pending=0, counters 0.
- Latency:
  - Request pulse at cycle 0 with state IDLE: pending is set at edge 1.
  - `snd_start_n` goes low and `snd_type` is valid from edge 2.
  - `busy` rises at edge 2.
- `snd_type` is valid no later than the first low strobe cycle. The player detects the falling edge through its 3-flop sync roughly 3 cycles later.
- Back-to-back sounds: the next strobe starts 1 cycle after returning to IDLE. The earliest case is edge (total + 1) relative to the previous strobe start.
- Simultaneous requests of different types in one cycle: all are latched, then issued in priority order.
- Reset asserted mid-sound: outputs return to reset values immediately and asynchronously. `snd_start_n` returning high does not create a falling edge at the player. Any tail of the sound already playing is not tracked.

## Test plan
Parameters for all scenarios: CLK_FREQ=1000 (long 100, short 40), GAP_CYCLES=16, STROBE_CYCLES=4.
- Single `req_drop` at cycle 0:
  - `snd_start_n` is low during edges 2–5, `snd_type`=01.
  - `busy` stays high for 2×41+8+16=106 cycles, then falls.
- `req_drop`, `req_error` and `req_victory` in the same cycle:
  - Victory plays first (`snd_type`=11, busy for 13×101+24=1337 cycles).
  - Error (10) follows, busy 226.
  - Drop is never issued.
- `req_start` at cycle 0, then `req_start` three more times during playback:
  - Exactly one further start sound (busy 428) plays after the first.
- `req_error` in the same cycle that error is issued:
  - The request is absorbed. Exactly one strobe occurs.
- `mute`=1 with error pending and a drop in flight:
  - The drop completes its 106 busy cycles.
  - Pending is cleared and no further strobe occurs.
  - After `mute`=0, the next `req_drop` plays normally.
- `rst` pulsed during WAIT of victory:
  - Outputs go to 1/00/0 immediately. Pending is cleared.
  - A `req_start` issued after reset strobes 2 cycles later.
